// File: rtl/line_clear.sv
// line_clear: scans a Tetris-style board from the bottom row upward, removes
// every fully occupied row and shifts the rows above it down by one. One row
// is examined per clock and one shift is performed per clock.
//
// Optional feature: define LINE_CLEAR_SCORE_EN to register a score increment
// (0/100/300/500/800 for 0/1/2/3/4+ cleared rows) alongside done. Without the
// macro, score_add is tied to zero.
module line_clear #(
  parameter int ROWS  = 20,
  parameter int COLS  = 10,
  parameter int CNT_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ROWS*COLS-1:0]   board_in,
  output logic                   busy,
  output logic                   done,
  output logic [ROWS*COLS-1:0]   board_out,
  output logic [CNT_W-1:0]       lines_cleared,
  output logic [11:0]            score_add
);

  localparam int BITS  = ROWS * COLS;
  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [BITS-1:0]   work;
  logic [BITS-1:0]   shifted;
  logic [IDX_W-1:0]  row_idx;
  logic [CNT_W-1:0]  cnt;
  logic              row_full;
  logic              finish;

  // The row currently under inspection is full when every cell is occupied.
  assign row_full = &work[int'(row_idx) * COLS +: COLS];

  // Scan has reached the top row and found nothing left to clear.
  assign finish = (state == SCAN) && !row_full && (row_idx == '0);

  // Board with row row_idx removed: rows 1..row_idx take the row above,
  // row 0 becomes empty, rows below row_idx are untouched.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    shifted = work;
    for (int r = 0; r < ROWS; r++) begin
      if (r == 0) begin
        shifted[0 +: COLS] = '0;
      end else if (r <= int'(row_idx)) begin
        shifted[r * COLS +: COLS] = work[(r - 1) * COLS +: COLS];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers see the values from before the edge.
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: walk rows bottom-up, detour through SHIFT on a full row.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = SCAN;
      SCAN: begin
        if (row_full) begin
          next_state = SHIFT;
        end else if (row_idx == '0) begin
          next_state = DONE;
        end
      end
      SHIFT: next_state = SCAN;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: capture the job, step the row index, apply shifts, publish result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the work board is an ordinary register bank, not a RAM, so it is
      // cleared on reset like the rest of the state.
      work          <= '0;
      row_idx       <= '0;
      cnt           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      board_out     <= '0;
      lines_cleared <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work    <= board_in;
            row_idx <= LAST_ROW;
            cnt     <= '0;
            busy    <= 1'b1;
          end
        end
        SCAN: begin
          if (finish) begin
            board_out     <= work;
            lines_cleared <= cnt;
            done          <= 1'b1;
          end else if (!row_full) begin
            row_idx <= row_idx - 1'b1;
          end
        end
        SHIFT: begin
          // row_idx stays put so the row that dropped into place is re-checked.
          work <= shifted;
          cnt  <= cnt + 1'b1;
        end
        DONE: begin
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef LINE_CLEAR_SCORE_EN
  function automatic logic [11:0] score_for(input logic [CNT_W-1:0] k);
    if (k == 0)      return 12'd0;
    else if (k == 1) return 12'd100;
    else if (k == 2) return 12'd300;
    else if (k == 3) return 12'd500;
    else             return 12'd800;
  endfunction

  // Score increment is published with the result and held until the next one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      score_add <= '0;
    end else if (finish) begin
      score_add <= score_for(cnt);
    end
  end
`else
  assign score_add = '0;
`endif

endmodule

// File: doc/line_clear.md
Name: line_clear

Overview:
- Sits directly upstream of the VGA display stage, between the game-logic board register and the `board` input of the display.
- After a brick locks, game logic pulses `start` with the merged board. The block finds and removes every full row, then shifts the rows above downward.
- It returns the compacted board plus a count of cleared lines, which the game logic latches back into its board register.
- Sequential scan engine: one row examined per clock, one row-shift per clock.

Parameters:
- ROWS, 20, board height in rows.
- COLS, 10, board width in columns.
- CNT_W, 5, width of lines_cleared; must hold ROWS.

Ports:
- clk  input  1  system clock (100 MHz domain).
- rst  input  1  synchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- board_in  input  ROWS*COLS  board to compact; sampled on the accepted start edge.
- busy  output  1  high from the accepted start until the clock after done.
- done  output  1  one-cycle completion pulse.
- board_out  output  ROWS*COLS  compacted board; valid when done=1, held until the next done.
- lines_cleared  output  CNT_W  number of rows removed; valid with done, held until the next done.
- score_add  output  12  score increment; see Optional Feature.

Behaviour:
- Board layout:
  - Row r occupies bits [r*COLS +: COLS]; row 0 is the top row, row ROWS-1 the bottom.
  - Bit = 1 means an occupied cell.
- Reset: when rst=0 at a clock edge:
  - state <= IDLE;
  - busy, done, board_out, lines_cleared, score_add all <= 0;
  - internal work board, row index and count <= 0.
  - Reset mid-operation abandons the job; no done is produced.
- FSM states: IDLE, SCAN, SHIFT, DONE.
- IDLE:
  - busy=0.
  - On start=1: work <= board_in, row_idx <= ROWS-1, cnt <= 0, busy <= 1, go to SCAN.
- SCAN:
  - If work row row_idx is all ones, go to SHIFT.
  - Else if row_idx==0: board_out <= work, lines_cleared <= cnt, done <= 1, go to DONE.
  - Else row_idx <= row_idx-1 and stay in SCAN.
- SHIFT:
  - For every r in 1..row_idx, row r <= row r-1. Row 0 <= all zeros. Rows below row_idx are unchanged.
  - cnt <= cnt+1.
  - Return to SCAN with row_idx unchanged, so the same row is re-checked; this handles adjacent full rows.
- DONE: lasts one cycle; done <= 0, busy <= 0, go to IDLE.
- start is ignored in SCAN, SHIFT and DONE; there is no queuing.
- Latency:
  - With k rows cleared, done is high in the cycle after edge number ROWS+2k, counting the start-sampling edge as edge 0.
  - A new start is accepted no earlier than the cycle done is low again.
- Boundaries:
  - Empty board: k=0; board_out=board_in; done after ROWS edges.
  - All-full board: k=ROWS; board_out=0; lines_cleared=ROWS.
  - Row 0 full: the shift inserts zeros only; the re-check sees an empty row.
  - board_in changing while busy has no effect.
  - start held high continuously: a new job is accepted on each IDLE entry.

Optional Feature:
- Macro: LINE_CLEAR_SCORE_EN.
- Defined:
  - score_add is registered with done, held until the next done, and reset to 0.
  - Values: score_add = 0, 100, 300, 500 for k = 0, 1, 2, 3; score_add = 800 for k >= 4.
- Not defined: score_add is tied to 0 and no score logic is synthesized. The port remains, so the interface is unchanged.

Test Plan:
- Reset and idle: rst=0 for 2 cycles, then rst=1, with start=0 → busy=0, done=0, board_out=0, lines_cleared=0, score_add=0.
- Empty board: board_in=0, start pulse → done exactly 20 edges later; board_out=0; lines_cleared=0; busy low the cycle after done.
- Two separated full rows:
  - Stimulus: rows 19 and 17 = 10'h3FF; row 18 = 10'h001; row 16 = 10'h200; others 0.
  - Response: done at edge 24; lines_cleared=2; row 19=10'h001; row 18=10'h200; rows 0..17=0; score_add=300 with macro, 0 without.
- Four adjacent full rows:
  - Stimulus: rows 16..19 = 10'h3FF; row 15 = 10'h155.
  - Response: lines_cleared=4; row 19=10'h155; all other rows 0; done at edge 28; score_add=800 with macro.
- All-full board: every row = 10'h3FF → lines_cleared=20, board_out=0, done at edge 60.
- Start ignored and reset abort:
  - Pulse start again while busy → no effect on the result and only one done.
  - Separately, drive rst=0 during SHIFT → IDLE next cycle, busy=0, no done, and a fresh start works normally.
